// File: rtl/gate_sensor_conditioner_if.sv
// gate_sensor_conditioner_if: raw gate switches in, clean levels/events/stuck flags out
interface gate_sensor_conditioner_if;
  logic gate_in_raw;
  logic gate_out_raw;
  logic gate_in_level;
  logic gate_out_level;
  logic car_in_pulse;
  logic car_out_pulse;
  logic in_stuck;
  logic out_stuck;
  modport master (
    output gate_in_raw, gate_out_raw,
    input  gate_in_level, gate_out_level, car_in_pulse, car_out_pulse, in_stuck, out_stuck
  );
  modport slave (
    input  gate_in_raw, gate_out_raw,
    output gate_in_level, gate_out_level, car_in_pulse, car_out_pulse, in_stuck, out_stuck
  );
endinterface

// File: rtl/gate_sensor_conditioner.sv
// gate_sensor_conditioner: sync, debounce and passage detection for entry/exit gate switches
module gate_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input logic                       clk_2,
  input logic                       reset,
  gate_sensor_conditioner_if.slave  bus
);
  localparam int DW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int OW = $clog2(STUCK_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [OW-1:0] STUCK_MAX = OW'(STUCK_CYCLES - 1);
  typedef enum logic [1:0] {CLOSED, OPEN, STUCK} state_t;
  logic [1:0] raw_v;
  assign raw_v = {bus.gate_out_raw, bus.gate_in_raw};
  for (genvar g = 0; g < 2; g++) begin : ch
    logic s1, s2, lvl, rise, pulse, stuck;
    logic [DW-1:0] deb;
    logic [OW-1:0] cnt;
    state_t st, st_n;
    assign rise = s2 && !lvl && deb == DEB_MAX;
    // CLOSED also opens on a level already high, so a rise that lands while closing is not lost
    always_comb begin
      st_n = st;
      st_n = (st == CLOSED) ? ((rise || lvl) ? OPEN : CLOSED) :
             !lvl ? CLOSED :
             (st == OPEN && cnt == STUCK_MAX) ? STUCK : st;
    end
    always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        deb   <= '0;
        cnt   <= '0;
        st    <= CLOSED;
        pulse <= 1'b0;
        stuck <= 1'b0;
      end else begin
        s1    <= raw_v[g];
        s2    <= s1;
        deb   <= (s2 == lvl || deb == DEB_MAX) ? '0 : deb + 1'b1;
        lvl   <= (s2 != lvl && deb == DEB_MAX) ? s2 : lvl;
        cnt   <= (st != OPEN) ? '0 : (&cnt ? cnt : cnt + 1'b1);
        st    <= st_n;
        pulse <= st == OPEN && !lvl;
        stuck <= st_n == STUCK;
      end
    end
  end
  assign bus.gate_in_level  = ch[0].lvl;
  assign bus.gate_out_level = ch[1].lvl;
  assign bus.car_in_pulse   = ch[0].pulse;
  assign bus.car_out_pulse  = ch[1].pulse;
  assign bus.in_stuck       = ch[0].stuck;
  assign bus.out_stuck      = ch[1].stuck;
endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// tb_gate_sensor_conditioner: directed timing checks plus randomized raw-switch traffic against a
// window-based reference model of debounce, passage and stuck rules
module tb_gate_sensor_conditioner;
  localparam int D = 4;
  localparam int S = 16;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  gate_sensor_conditioner_if bus();
  gate_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (
    .clk_2(clk_2), .reset(reset), .bus(bus)
  );
  always #5 clk_2 = ~clk_2;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [D+1:0] h [2];
  logic [2:0] lvh [2];
  int rise [2];
  logic [1:0] ep, es;
  logic [5:0] act;
  assign act = {bus.out_stuck, bus.in_stuck, bus.car_out_pulse, bus.car_in_pulse,
                bus.gate_out_level, bus.gate_in_level};
  function automatic logic [5:0] expv();
    return {es, ep, lvh[1][0], lvh[0][0]};
  endfunction
  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      h[c] = '0;
      lvh[c] = '0;
    end
    ep = '0;
    es = '0;
  endtask
  // level flips once the last D synced samples (raw delayed 2 edges) all disagree with it;
  // a passage pulses one edge after the fall if it lasted under S edges, else it was stuck
  task automatic model_step();
    logic [D-1:0] win;
    logic nl;
    n++;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      h[c] = {h[c][D:0], (c == 0) ? bus.gate_in_raw : bus.gate_out_raw};
      win = h[c][D+1:2];
      nl = lvh[c][0] ? ((win == '0) ? 1'b0 : 1'b1) : ((&win) ? 1'b1 : 1'b0);
      lvh[c] = {lvh[c][1:0], nl};
      if (nl && !lvh[c][1]) rise[c] = n;
      ep[c] = !lvh[c][1] && lvh[c][2] && (n - 1 - rise[c] < S);
      es[c] = lvh[c][1] && (n - rise[c] >= S);
    end
  endtask
  task automatic tick();
    @(posedge clk_2);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    int first = 0;
    bus.gate_in_raw = 1'b1;
    bus.gate_out_raw = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_clear();
    total++;
    if (act !== 6'b0) begin bad++; $display("FAIL reset_async got=%b want=000000", act); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (act !== 6'b0) begin bad++; $display("FAIL reset_hold got=%b want=000000", act); end
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.gate_in_level && first == 0) first = k;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL reset_release k=%0d got=%b want=%b", k, act, expv()); end
    end
    total++;
    if (first != D + 2) begin bad++; $display("FAIL reset_level_edge got=%0d want=%0d", first, D + 2); end
    bus.gate_in_raw = 1'b0;
    bus.gate_out_raw = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      total++;
      if (act !== expv()) begin bad++; $display("FAIL reset_settle got=%b want=%b", act, expv()); end
    end
  endtask
  task automatic test_passage();
    int up = 0, pe = 0, pc = 0;
    bus.gate_in_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.gate_in_level && up == 0) up = k;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL passage_open got=%b want=%b", act, expv()); end
    end
    bus.gate_in_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.car_in_pulse) begin pc++; if (pe == 0) pe = k; end
      total++;
      if (act !== expv()) begin bad++; $display("FAIL passage_close got=%b want=%b", act, expv()); end
    end
    total++;
    if (up != D + 2) begin bad++; $display("FAIL passage_rise got=%0d want=%0d", up, D + 2); end
    total++;
    if (pe != D + 3) begin bad++; $display("FAIL passage_pulse_edge got=%0d want=%0d", pe, D + 3); end
    total++;
    if (pc != 1) begin bad++; $display("FAIL passage_pulse_width got=%0d want=1", pc); end
  endtask
  task automatic test_glitch();
    int hits = 0;
    for (int g = 1; g <= 3; g += 2) begin
      bus.gate_out_raw = 1'b1;
      for (int k = 0; k < g; k++) begin
        tick();
        if (bus.gate_out_level || bus.car_out_pulse) hits++;
      end
      bus.gate_out_raw = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (bus.gate_out_level || bus.car_out_pulse) hits++;
        total++;
        if (act !== expv()) begin bad++; $display("FAIL glitch_model got=%b want=%b", act, expv()); end
      end
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL glitch_ignored got=%0d want=0", hits); end
  endtask
  task automatic test_stuck();
    int up = 0, sk = 0, pc = 0;
    bus.gate_in_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.gate_in_level && up == 0) up = k;
      if (bus.in_stuck && sk == 0) sk = k;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL stuck_open got=%b want=%b", act, expv()); end
    end
    total++;
    if (sk - up != S) begin bad++; $display("FAIL stuck_delay got=%0d want=%0d", sk - up, S); end
    bus.gate_in_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.car_in_pulse) pc++;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL stuck_close got=%b want=%b", act, expv()); end
    end
    total++;
    if (bus.in_stuck !== 1'b0) begin bad++; $display("FAIL stuck_clear got=%b want=0", bus.in_stuck); end
    total++;
    if (pc != 0) begin bad++; $display("FAIL stuck_no_pulse got=%0d want=0", pc); end
  endtask
  task automatic test_simultaneous();
    int both = 0, pin = 0;
    bus.gate_in_raw = 1'b1;
    bus.gate_out_raw = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.gate_in_raw = 1'b0;
    bus.gate_out_raw = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.car_in_pulse && bus.car_out_pulse) both++;
      if (bus.car_in_pulse) pin++;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL simul_model got=%b want=%b", act, expv()); end
    end
    total++;
    if (both != 1 || pin != 1) begin bad++; $display("FAIL simul_pulses got=%0d/%0d want=1/1", both, pin); end
  endtask
  task automatic test_reset_mid();
    int pc = 0;
    bus.gate_in_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    #2 reset = 1'b0;
    #1;
    model_clear();
    total++;
    if (act !== 6'b0) begin bad++; $display("FAIL midreset_async got=%b want=000000", act); end
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    tick();
    tick();
    bus.gate_in_raw = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus.car_in_pulse) pc++;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL midreset_model got=%b want=%b", act, expv()); end
    end
    total++;
    if (pc != 0) begin bad++; $display("FAIL midreset_no_pulse got=%0d want=0", pc); end
  endtask
  task automatic test_random();
    int len;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        #1;
        model_clear();
        total++;
        if (act !== 6'b0) begin bad++; $display("FAIL random_reset got=%b want=000000", act); end
        tick();
        tick();
        reset = 1'b1;
      end
      bus.gate_in_raw = 1'($urandom_range(0, 1));
      bus.gate_out_raw = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 24);
      for (int k = 0; k < len; k++) begin
        tick();
        total++;
        if (act !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", n, act, expv()); end
      end
    end
  endtask
  initial begin
    bus.gate_in_raw = 1'b0;
    bus.gate_out_raw = 1'b0;
    rise[0] = 0;
    rise[1] = 0;
    model_clear();
    test_reset();
    test_passage();
    test_glitch();
    test_stuck();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
